// File: rtl/ram_arbiter.sv
// ram_arbiter -- two-master arbiter in front of a single-port data RAM.
//
// Master 0 (CPU data port) and master 1 (DMA/loader) share one RAM port.
// The owning master's request is steered straight through to the RAM in the
// same cycle; its ack equals its ce, so every ack cycle is exactly one RAM
// access (write committed on that edge, read data returned combinationally).
// The waiting master sees ack = 0 and must hold its request stable.
//
// Parameters:
//   MAX_HOLD  consecutive accesses allowed to a limited owner while the other
//             master waits (legal 1..15)
//
// Configuration macro:
//   ARB_ROUND_ROBIN_EN  defined  : idle contention goes to the master that was
//                                  not granted last; both masters limited.
//                       undefined: master 0 wins idle contention and holds
//                                  without limit; only master 1 is limited.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   m{0,1}_ce_i/we_i          request / write enable
//   m{0,1}_addr_i/sel_i/data_i byte address, byte selects, write data
//   m{0,1}_data_o/ack_o       read data, access performed this cycle
//   ram_*_o, ram_data_i       shared RAM port (read data combinational)
//   owner_o                   00 IDLE, 01 OWN0, 10 OWN1
module ram_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_ce_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_data_i,
  output logic [31:0] m0_data_o,
  output logic        m0_ack_o,
  input  logic        m1_ce_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_data_i,
  output logic [31:0] m1_data_o,
  output logic        m1_ack_o,
  output logic        ram_ce_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [3:0]  ram_sel_o,
  output logic [31:0] ram_data_o,
  input  logic [31:0] ram_data_i,
  output logic [1:0]  owner_o
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_OWN0 = 2'b01;
  localparam logic [1:0] S_OWN1 = 2'b10;

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic RR_EN    = 1'b1;
  localparam logic LIMIT_M0 = 1'b1;
`else
  localparam logic RR_EN    = 1'b0;
  localparam logic LIMIT_M0 = 1'b0;
`endif

  // Counter value before the ack that is the MAX_HOLD-th access of a tenure.
  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  logic [1:0] r_state, w_next;
  logic [3:0] r_cnt, w_cnt_next;
  logic       r_last, w_last_next;
  logic       w_win;
  logic [3:0] w_cnt_inc;

  // Winner of contention seen from IDLE.
  assign w_win     = RR_EN ? ~r_last : 1'b0;
  assign w_cnt_inc = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;
  assign owner_o   = r_state;

  always_comb begin
    w_next      = r_state;
    w_cnt_next  = r_cnt;
    w_last_next = r_last;
    case (r_state)
      S_IDLE: begin
        if (m0_ce_i && m1_ce_i) begin
          w_next      = w_win ? S_OWN1 : S_OWN0;
          w_last_next = w_win;
          w_cnt_next  = '0;
        end else if (m0_ce_i) begin
          w_next      = S_OWN0;
          w_last_next = 1'b0;
          w_cnt_next  = '0;
        end else if (m1_ce_i) begin
          w_next      = S_OWN1;
          w_last_next = 1'b1;
          w_cnt_next  = '0;
        end
      end
      S_OWN0: begin
        if (!m0_ce_i) begin
          w_next = m1_ce_i ? S_OWN1 : S_IDLE;
          if (m1_ce_i) begin
            w_last_next = 1'b1;
            w_cnt_next  = '0;
          end
        end else if (m1_ce_i && LIMIT_M0 && (r_cnt >= HOLD_LAST)) begin
          // >= so a waiter arriving after saturation is served after one access
          w_next      = S_OWN1;
          w_last_next = 1'b1;
          w_cnt_next  = '0;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      S_OWN1: begin
        if (!m1_ce_i) begin
          w_next = m0_ce_i ? S_OWN0 : S_IDLE;
          if (m0_ce_i) begin
            w_last_next = 1'b0;
            w_cnt_next  = '0;
          end
        end else if (m0_ce_i && (r_cnt >= HOLD_LAST)) begin
          w_next      = S_OWN0;
          w_last_next = 1'b0;
          w_cnt_next  = '0;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_last  <= w_last_next;
    end
  end

  // Owner's request is routed straight to the RAM; IDLE drives everything low.
  always_comb begin
    ram_ce_o   = 1'b0;
    ram_we_o   = 1'b0;
    ram_addr_o = '0;
    ram_sel_o  = '0;
    ram_data_o = '0;
    m0_ack_o   = 1'b0;
    m1_ack_o   = 1'b0;
    m0_data_o  = '0;
    m1_data_o  = '0;
    case (r_state)
      S_OWN0: begin
        ram_ce_o   = m0_ce_i;
        ram_we_o   = m0_we_i;
        ram_addr_o = m0_addr_i;
        ram_sel_o  = m0_sel_i;
        ram_data_o = m0_data_i;
        m0_ack_o   = m0_ce_i;
        m0_data_o  = ram_data_i;
      end
      S_OWN1: begin
        ram_ce_o   = m1_ce_i;
        ram_we_o   = m1_we_i;
        ram_addr_o = m1_addr_i;
        ram_sel_o  = m1_sel_i;
        ram_data_o = m1_data_i;
        m1_ack_o   = m1_ce_i;
        m1_data_o  = ram_data_i;
      end
      default: ;
    endcase
  end

endmodule
